// File: rtl/one_hot_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_sequencer
// Description : Registered one-hot position generator feeding the one-hot to
//               BCD encoder. Exactly one bit is active. That bit rotates up
//               or down by one position on each advance event. An advance
//               comes from a manual step or from a prescaled auto-tick. The
//               block also supports a direct load of a position, and it
//               pulses wrap whenever an advance crosses the MSB/bit0 seam.
//
//   Parameters:
//     WIDTH     number of one-hot positions (>= 2)
//     PRESCALE  auto mode clocks per advance (>= 1, 1 = every clock)
//
//   Ports:
//     clk       rising-edge clock
//     rst       synchronous active-high reset
//     en        enables advancing (load is not gated by en)
//     auto      1 = advance on prescaler tick, 0 = advance on step
//     step      manual advance request
//     dir       1 = rotate up (bit i -> i+1), 0 = rotate down
//     load      load position load_idx this cycle
//     load_idx  position to load (0 .. WIDTH-1; out-of-range is ignored)
//     one_hot   registered current position
//     wrap      one-cycle pulse after an advance that wrapped around
//
//   Build option:
//     ONE_HOT_SEQ_STEP_EDGE_EN  when defined, step is edge-detected, so a
//                               held step gives a single advance. When it is
//                               undefined, step is level-sensitive.
//
// Revision    : 1.0  initial release
// ============================================================================
module one_hot_sequencer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 4,
    localparam int IDX_W   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             auto,
    input  logic             step,
    input  logic             dir,
    input  logic             load,
    input  logic [IDX_W-1:0] load_idx,
    output logic [WIDTH-1:0] one_hot,
    output logic             wrap
);

    // A prescaler of 1 still needs a 1-bit counter that simply stays at zero.
    localparam int              CNT_W      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] c_TICK_CNT = CNT_W'(PRESCALE - 1);
    // One extra bit keeps the range check meaningful when WIDTH is a power of 2.
    localparam logic [IDX_W:0]   c_WIDTH    = (IDX_W + 1)'(WIDTH);

    logic [WIDTH-1:0] r_one_hot;
    logic             r_wrap;
    logic [CNT_W-1:0] r_cnt;

    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_run;
    logic             w_tick;
    logic             w_step_req;
    logic             w_adv;
    logic             w_legal;
    logic             w_idx_ok;
    logic [WIDTH-1:0] w_load_vec;
    logic [WIDTH-1:0] w_rot;
    logic             w_wrap_nxt;

    // ------------------------------------------------------------------
    // Step request: edge or level
    // ------------------------------------------------------------------
`ifdef ONE_HOT_SEQ_STEP_EDGE_EN
    logic r_step_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_step_q <= 1'b0;
        end else begin
            r_step_q <= step;
        end
    end

    // The reset value of 0 lets a step that is already high when reset
    // releases count as one fresh request.
    assign w_step_req = step & ~r_step_q;
`else
    assign w_step_req = step;
`endif

    // ------------------------------------------------------------------
    // Prescaler: counts only while auto-advancing without a load
    // ------------------------------------------------------------------
    assign w_run  = en & auto & ~load;
    assign w_tick = w_run & (r_cnt == c_TICK_CNT);

    always_comb begin
        w_cnt_nxt = '0;
        if (w_run && !w_tick) begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
        end
    end

    assign w_adv = en & (auto ? w_tick : w_step_req);

    // ------------------------------------------------------------------
    // Position datapath
    // ------------------------------------------------------------------
    // The value is legal only when it is nonzero and has a single bit set.
    assign w_legal    = (r_one_hot != '0) && ((r_one_hot & (r_one_hot - WIDTH'(1))) == '0);
    assign w_idx_ok   = ({1'b0, load_idx} < c_WIDTH);
    assign w_load_vec = WIDTH'(1) << load_idx;

    assign w_rot      = dir ? {r_one_hot[WIDTH-2:0], r_one_hot[WIDTH-1]}
                            : {r_one_hot[0], r_one_hot[WIDTH-1:1]};
    assign w_wrap_nxt = dir ? r_one_hot[WIDTH-1] : r_one_hot[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_one_hot <= WIDTH'(1);
            r_wrap    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            if (!w_legal) begin
                // Recover from a corrupted position before honouring any request.
                r_one_hot <= WIDTH'(1);
                r_wrap    <= 1'b0;
            end else if (load) begin
                if (w_idx_ok) begin
                    r_one_hot <= w_load_vec;
                end
                r_wrap <= 1'b0;
            end else if (w_adv) begin
                r_one_hot <= w_rot;
                r_wrap    <= w_wrap_nxt;
            end else begin
                r_wrap <= 1'b0;
            end
        end
    end

    assign one_hot = r_one_hot;
    assign wrap    = r_wrap;

endmodule
`default_nettype wire
